// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, single-outstanding imem reads, IF/ID register
// Optional HLT predecode stop enabled by defining FETCH_HALT_PREDECODE_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_KILL = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] instr_q, pc_plus2_q;
    logic        valid_q;

    logic        load;
    logic [15:0] load_instr;
    logic [15:0] pc_plus2;
    logic [15:0] target;

    assign pc_plus2 = pc_q + 16'd2;
    assign target   = redirect_pc & 16'hFFFE;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_instr = imem_rdata;
        case (state_q)
            S_REQ: begin
                state_d = redirect ? S_KILL : S_WAIT;
                if (redirect) pc_d = target;
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_valid ? S_REQ : S_KILL;
                end else if (imem_valid) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                load_instr = hold_q;
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    load = 1'b1;
                end
            end
            S_KILL: begin
                // A return that coincides with a new redirect still retires the outstanding read.
                if (redirect) pc_d = target;
                if (imem_valid) state_d = S_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_REQ;
        endcase

        if (load) begin
`ifdef FETCH_HALT_PREDECODE_EN
            if (load_instr[15:12] == 4'hF) begin
                state_d = S_HALT;
            end else begin
                pc_d    = pc_plus2;
                state_d = S_REQ;
            end
`else
            pc_d    = pc_plus2;
            state_d = S_REQ;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // IF/ID register: flush beats stall beats a new load; anything else is a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= 16'h0000;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (flush) begin
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else if (stall) begin
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load) begin
            instr_q    <= load_instr;
            pc_plus2_q <= pc_plus2;
            valid_q    <= 1'b1;
        end else begin
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end
    end

    assign imem_req    = (state_q == S_REQ) && !rst;
    assign imem_addr   = pc_q;
    assign if_instr    = instr_q;
    assign if_pc_plus2 = pc_plus2_q;
    assign if_valid    = valid_q;

`ifdef FETCH_HALT_PREDECODE_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - cycle-vector bench for fetch_stage; memory returns driven directly per cycle
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        halted;

    fetch_stage #(.RESET_PC(16'h0040)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .if_instr    (if_instr),
        .if_pc_plus2 (if_pc_plus2),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs for the cycle, expected imem outputs during it,
    // expected IF/ID and halted after its rising edge.
    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [15:0] rpc;
        logic        iv;
        logic [15:0] rdata;
        logic        ereq;
        logic [15:0] eaddr;
        logic [15:0] einstr;
        logic [15:0] epc2;
        logic        evalid;
        logic        ehalt;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    function automatic vec_t mk(logic r, logic s, logic f, logic rd, logic [15:0] rpc,
                                logic iv, logic [15:0] rdata, logic ereq, logic [15:0] eaddr,
                                logic [15:0] einstr, logic [15:0] epc2, logic evalid, logic ehalt);
        vec_t v;
        v.rst = r;  v.stall = s;  v.flush = f;  v.redir = rd;  v.rpc = rpc;
        v.iv = iv;  v.rdata = rdata;  v.ereq = ereq;  v.eaddr = eaddr;
        v.einstr = einstr;  v.epc2 = epc2;  v.evalid = evalid;  v.ehalt = ehalt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run_vec(input vec_t v);
        rst         = v.rst;
        stall       = v.stall;
        flush       = v.flush;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imem_valid  = v.iv;
        imem_rdata  = v.rdata;
        #1;
        chk("imem_req", {15'd0, imem_req}, {15'd0, v.ereq});
        chk("imem_addr", imem_addr, v.eaddr);
        @(posedge clk);
        #1;
        chk("if_instr", if_instr, v.einstr);
        chk("if_pc_plus2", if_pc_plus2, v.epc2);
        chk("if_valid", {15'd0, if_valid}, {15'd0, v.evalid});
        chk("halted", {15'd0, halted}, {15'd0, v.ehalt});
        @(negedge clk);
        cur++;
    endtask

    initial begin
        // r s f rd rpc iv rdata | req addr | instr pc2 valid halt
        // Reset PC 0x0040, N=1 return of 0x1234
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0040, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h1234, 0,16'h0040, 16'h1234,16'h0042,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0042, 16'h0000,16'h0042,0,0));
        // N=3 with stall over the return: WAIT -> HOLD -> single delivery
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0042, 16'h0000,16'h0042,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0000,0,16'h0000, 0,16'h0042, 16'h0000,16'h0042,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0000,1,16'h5678, 0,16'h0042, 16'h0000,16'h0042,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0042, 16'h5678,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0044, 16'h0000,16'h0044,0,0));
        // Redirect to 0x0101 in WAIT -> KILL, late data dropped, refetch at 0x0100
        vecs.push_back(mk(0,0,1,1,16'h0101,0,16'h0000, 0,16'h0044, 16'h0000,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0100, 16'h0000,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'hDEAD, 0,16'h0100, 16'h0000,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0100, 16'h0000,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h2222, 0,16'h0100, 16'h2222,16'h0102,1,0));
        // Stall holds a valid entry, then flush beats stall
        vecs.push_back(mk(0,1,0,0,16'h0000,0,16'h0000, 1,16'h0102, 16'h2222,16'h0102,1,0));
        vecs.push_back(mk(0,1,1,0,16'h0000,0,16'h0000, 0,16'h0102, 16'h0000,16'h0102,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h3333, 0,16'h0102, 16'h3333,16'h0104,1,0));
        // Redirect coinciding with valid in WAIT: data dropped, straight to REQ at 0xFFFE
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0104, 16'h0000,16'h0104,0,0));
        vecs.push_back(mk(0,0,1,1,16'hFFFF,1,16'h4444, 0,16'h0104, 16'h0000,16'h0104,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'hFFFE, 16'h0000,16'h0104,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h5555, 0,16'hFFFE, 16'h5555,16'h0000,1,0));
        // Wrapped to 0x0000; redirect during REQ -> KILL
        vecs.push_back(mk(0,0,1,1,16'h0010,0,16'h0000, 1,16'h0000, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h6666, 0,16'h0010, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0010, 16'h0000,16'h0000,0,0));
        // Redirect while in HOLD drops the buffered word
        vecs.push_back(mk(0,1,0,0,16'h0000,1,16'h7777, 0,16'h0010, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,1,1,1,16'h0020,0,16'h0000, 0,16'h0010, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0020, 16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,16'h8888, 0,16'h0020, 16'h8888,16'h0022,1,0));

        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;  redirect = 1'b0;
        redirect_pc = 16'h0000;  imem_valid = 1'b0;  imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_imem_addr", imem_addr, 16'h0040);
        chk("rst_if_instr", if_instr, 16'h0000);
        chk("rst_if_pc_plus2", if_pc_plus2, 16'h0000);
        chk("rst_if_valid", {15'd0, if_valid}, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // HLT at 0x0010
        run_vec(mk(0,0,1,1,16'h0010,0,16'h0000, 1,16'h0022, 16'h0000,16'h0022,0,0));
        run_vec(mk(0,0,0,0,16'h0000,1,16'h0000, 0,16'h0010, 16'h0000,16'h0022,0,0));
        run_vec(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0010, 16'h0000,16'h0022,0,0));
`ifdef FETCH_HALT_PREDECODE_EN
        run_vec(mk(0,0,0,0,16'h0000,1,16'hF000, 0,16'h0010, 16'hF000,16'h0012,1,1));
        run_vec(mk(0,0,0,1,16'h0200,0,16'h0000, 0,16'h0010, 16'h0000,16'h0012,0,1));
        run_vec(mk(0,1,0,1,16'h0200,0,16'h0000, 0,16'h0010, 16'h0000,16'h0012,0,1));
        run_vec(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0010, 16'h0000,16'h0012,0,1));
        run_vec(mk(1,0,0,0,16'h0000,0,16'h0000, 0,16'h0010, 16'h0000,16'h0000,0,0));
`else
        run_vec(mk(0,0,0,0,16'h0000,1,16'hF000, 0,16'h0010, 16'hF000,16'h0012,1,0));
        run_vec(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0012, 16'h0000,16'h0012,0,0));
        run_vec(mk(0,0,0,0,16'h0000,1,16'h1111, 0,16'h0012, 16'h1111,16'h0014,1,0));
        run_vec(mk(1,0,0,0,16'h0000,0,16'h0000, 0,16'h0014, 16'h0000,16'h0000,0,0));
`endif
        // Out of reset: fetch restarts at RESET_PC
        run_vec(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0040, 16'h0000,16'h0000,0,0));
        run_vec(mk(0,0,0,0,16'h0000,1,16'hABCD, 0,16'h0040, 16'hABCD,16'h0042,1,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
